// File: rtl/code_encoder.sv
// code_encoder: packs decoded instruction fields into 32-bit instruction words.
// Each packed word is written to the next instruction-memory address in a load run.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; wrapped holds the result of the last run
//   RUN   | accepting one instruction per handshake and writing it out
//   DONE  | single-cycle end-of-run pulse; the last write is visible here
module code_encoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] remain;
    logic              xfer;
    logic              load_run;
    logic              clear_wrap;
    logic [31:0]       enc_word;

    // Opcodes 1..15 are register-register; everything else carries a 16-bit immediate.
    function automatic logic is_r_type(input logic [5:0] op);
        return (op[5:4] == 2'b00) && (op != 6'd0);
    endfunction

    // Build the instruction word; fields unused by the chosen format are dropped.
    function automatic logic [31:0] encode(
        input logic [5:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  shamt,
        input logic [15:0] imm
    );
        logic [31:0] word;
        if (is_r_type(op)) begin
            word = {op, rd, rs1, rs2, shamt, 6'b000000};
        end else begin
            word = {op, rd, rs1, imm};
        end
        return word;
    endfunction

    // Combinational packing of the currently presented fields.
    always_comb begin
        enc_word = encode(in_opcode, in_rd, in_rs1, in_rs2, in_shamt, in_imm);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived handshake/status outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        xfer       = 1'b0;
        load_run   = 1'b0;
        clear_wrap = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_wrap = 1'b1;
                    if (count != '0) begin
                        load_run   = 1'b1;
                        next_state = RUN;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                xfer     = in_valid;
                if (in_valid && (remain == ADDR_W'(1))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Run counters, sticky wrap flag and the registered memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt  <= '0;
            remain    <= '0;
            wrapped   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= xfer;
            if (load_run) begin
                addr_cnt <= base_addr;
                remain   <= count;
            end
            if (clear_wrap) begin
                wrapped <= 1'b0;
            end
            if (xfer) begin
                mem_addr  <= addr_cnt;
                mem_wdata <= enc_word;
                addr_cnt  <= addr_cnt + 1'b1;
                remain    <= remain - 1'b1;
                if (&addr_cnt) begin
                    wrapped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_code_encoder.sv
// Directed bench for code_encoder: inputs change on the falling edge, outputs are
// checked on the falling edge after each rising edge.
module tb_code_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] count;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        wrapped;

    int n_cmp = 0;
    int n_err = 0;

    code_encoder #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fields(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] sh, input logic [15:0] imm);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_shamt  = sh;
        in_imm    = imm;
    endtask

    task automatic write_chk(input string tag, input logic [15:0] a, input logic [31:0] d,
                             input logic dn);
        chk({tag, ".we"},   32'(mem_we), 32'd1);
        chk({tag, ".addr"}, 32'(mem_addr), 32'(a));
        chk({tag, ".data"}, mem_wdata, d);
        chk({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    task automatic kick(input logic [15:0] b, input logic [15:0] c);
        start     = 1'b1;
        base_addr = b;
        count     = c;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
        fields(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        @(negedge clk);
        tick();
        tick();

        // reset values
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.mem_we",   32'(mem_we), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.busy",     32'(busy), 32'd0);
        chk("rst.done",     32'(done), 32'd0);
        chk("rst.wrapped",  32'(wrapped), 32'd0);
        rst = 1'b0;
        tick();

        // R-type single word
        kick(16'h0010, 16'd1);
        chk("r.busy",     32'(busy), 32'd1);
        chk("r.in_ready", 32'(in_ready), 32'd1);
        chk("r.we_idle",  32'(mem_we), 32'd0);
        in_valid = 1'b1;
        fields(6'd3, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF);
        tick();
        in_valid = 1'b0;
        write_chk("r", 16'h0010, 32'h0C221900, 1'b1);
        chk("r.busy_done", 32'(busy), 32'd0);
        chk("r.ready_done", 32'(in_ready), 32'd0);
        tick();
        chk("r.done_clr", 32'(done), 32'd0);
        chk("r.we_clr",   32'(mem_we), 32'd0);
        chk("r.addr_hold", 32'(mem_addr), 32'h0010);

        // I-type then address-type, back to back
        kick(16'h0020, 16'd2);
        in_valid = 1'b1;
        fields(6'd16, 5'd5, 5'd6, 5'd9, 5'd9, 16'hBEEF);
        tick();
        write_chk("i0", 16'h0020, 32'h40A6BEEF, 1'b0);
        fields(6'd0, 5'd31, 5'd0, 5'd7, 5'd7, 16'h1234);
        tick();
        in_valid = 1'b0;
        write_chk("i1", 16'h0021, 32'h03E01234, 1'b1);
        tick();

        // backpressure: valid 1,0,0,1,1
        kick(16'h0100, 16'd3);
        in_valid = 1'b1;
        fields(6'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0001);
        tick();
        write_chk("bp0", 16'h0100, 32'h40000001, 1'b0);
        in_valid = 1'b0;
        fields(6'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h00EE);
        tick();
        chk("bp.gap1.we", 32'(mem_we), 32'd0);
        chk("bp.gap1.data", mem_wdata, 32'h40000001);
        tick();
        chk("bp.gap2.we", 32'(mem_we), 32'd0);
        chk("bp.gap2.busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        fields(6'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0002);
        tick();
        write_chk("bp1", 16'h0101, 32'h40000002, 1'b0);
        fields(6'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0003);
        tick();
        in_valid = 1'b0;
        write_chk("bp2", 16'h0102, 32'h40000003, 1'b1);
        tick();
        chk("bp.after.we", 32'(mem_we), 32'd0);

        // address wrap
        kick(16'hFFFE, 16'd3);
        in_valid = 1'b1;
        fields(6'd40, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0A0A);
        tick();
        write_chk("w0", 16'hFFFE, 32'hA0210A0A, 1'b0);
        chk("w0.wrapped", 32'(wrapped), 32'd0);
        tick();
        write_chk("w1", 16'hFFFF, 32'hA0210A0A, 1'b0);
        chk("w1.wrapped", 32'(wrapped), 32'd1);
        tick();
        in_valid = 1'b0;
        write_chk("w2", 16'h0000, 32'hA0210A0A, 1'b1);
        tick();
        chk("w.hold_idle", 32'(wrapped), 32'd1);
        tick();
        chk("w.hold_idle2", 32'(wrapped), 32'd1);

        // zero-count run clears wrapped, no writes
        kick(16'h0777, 16'd0);
        chk("z.done", 32'(done), 32'd1);
        chk("z.we",   32'(mem_we), 32'd0);
        chk("z.busy", 32'(busy), 32'd0);
        chk("z.wrapped", 32'(wrapped), 32'd0);
        tick();
        chk("z.done_clr", 32'(done), 32'd0);
        chk("z.we2", 32'(mem_we), 32'd0);

        // start during RUN is ignored
        kick(16'h0200, 16'd2);
        start = 1'b1; base_addr = 16'h0300; count = 16'd5;
        in_valid = 1'b1;
        fields(6'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'h000A);
        tick();
        start = 1'b0;
        write_chk("ign0", 16'h0200, 32'h4400000A, 1'b0);
        fields(6'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'h000B);
        tick();
        in_valid = 1'b0;
        write_chk("ign1", 16'h0201, 32'h4400000B, 1'b1);
        tick();

        // reset mid-run drops the pending write
        kick(16'h0400, 16'd4);
        in_valid = 1'b1;
        fields(6'd15, 5'd2, 5'd3, 5'd4, 5'd5, 16'h0000);
        tick();
        write_chk("mr0", 16'h0400, 32'h3C432140, 1'b0);
        tick();
        write_chk("mr1", 16'h0401, 32'h3C432140, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mr.we",    32'(mem_we), 32'd0);
        chk("mr.busy",  32'(busy), 32'd0);
        chk("mr.ready", 32'(in_ready), 32'd0);
        chk("mr.addr",  32'(mem_addr), 32'd0);
        chk("mr.data",  mem_wdata, 32'd0);
        chk("mr.done",  32'(done), 32'd0);
        kick(16'h0500, 16'd1);
        in_valid = 1'b1;
        fields(6'd63, 5'd0, 5'd0, 5'd0, 5'd0, 16'h5555);
        tick();
        in_valid = 1'b0;
        write_chk("fresh", 16'h0500, 32'hFC005555, 1'b1);
        tick();

        // start and rst together: rst wins
        rst = 1'b1; start = 1'b1; base_addr = 16'h0600; count = 16'd2;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("sr.busy", 32'(busy), 32'd0);
        tick();
        chk("sr.busy2", 32'(busy), 32'd0);
        chk("sr.done2", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
